// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the input side of the 1x3 router: the controller
// state encoding, the header field layout and the destination constants.
// Ports: none (package).
// ---------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_DATA,
        DROP,
        CHECK
    } state_e;

    // Header byte layout: destination in the low bits, payload length above.
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 6;

    // The one destination code that has no FIFO behind it.
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam int NUM_DEST = 3;

endpackage

// File: rtl/router_pkt_chk.sv
// ---------------------------------------------------------------------------
// router_pkt_chk
// Per-packet integrity tracker: running XOR parity, payload byte counter and
// the latched payload length, plus the compare logic used on the parity byte.
// Ports:
//   clock, resetn  - clock and asynchronous active-low reset
//   clear_i        - header accepted: seed parity with the header, zero count
//   update_i       - payload byte accepted: fold into parity, bump count
//   data_i         - current byte on the input bus
//   atLen_o        - payload count has reached the header length
//   checkFail_o    - data_i as parity byte would fail (parity or length)
// ---------------------------------------------------------------------------
module router_pkt_chk
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear_i,
    input  logic       update_i,
    input  logic [7:0] data_i,
    output logic       atLen_o,
    output logic       checkFail_o
);

    logic [7:0]       parity_q, parity_d;
    logic [LEN_W-1:0] count_q,  count_d;
    logic [LEN_W-1:0] len_q,    len_d;

    // A header restarts the accumulator from the header byte itself, so the
    // expected parity naturally covers header plus payload.
    always_comb begin
        parity_d = parity_q;
        count_d  = count_q;
        len_d    = len_q;
        if (clear_i) begin
            parity_d = data_i;
            count_d  = '0;
            len_d    = data_i[LEN_LSB +: LEN_W];
        end else if (update_i) begin
            parity_d = parity_q ^ data_i;
            count_d  = count_q + LEN_W'(1);
        end
    end

    // Plain state registers, cleared by reset so an aborted packet leaves
    // nothing behind.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
        end else begin
            parity_q <= parity_d;
            count_q  <= count_d;
            len_q    <= len_d;
        end
    end

    assign atLen_o     = (count_q == len_q);
    assign checkFail_o = (parity_q != data_i) | (count_q != len_q);

endmodule

// File: rtl/router_src_ctrl.sv
// ---------------------------------------------------------------------------
// router_src_ctrl
// Input-side packet controller of the 1x3 router. Decodes the header, steers
// each byte of a packet into one destination FIFO with zero latency, stalls
// the source while the target FIFO is full, and flags bad packets.
// Ports:
//   clock, resetn  - clock and asynchronous active-low reset
//   data_in        - packet byte from the source
//   pkt_valid      - high for header/payload, low for the parity byte
//   fifo_full      - per-destination FIFO full flags
//   busy           - source must hold its byte while high
//   error          - one-cycle pulse, packet failed its check
//   pkt_done       - one-cycle pulse, packet finished
//   fifo_data      - byte to the FIFOs (mirrors data_in)
//   fifo_we        - one-hot write enable per destination
// ---------------------------------------------------------------------------
module router_src_ctrl
    import router_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [DW-1:0]       data_in,
    input  logic                pkt_valid,
    input  logic [NUM_DEST-1:0] fifo_full,
    output logic                busy,
    output logic                error,
    output logic                pkt_done,
    output logic [DW-1:0]       fifo_data,
    output logic [NUM_DEST-1:0] fifo_we
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic                error_q, error_d;
    logic                pktDone_q, pktDone_d;

    logic [ADDR_W-1:0]   hdrDest;
    logic                hdrValid;
    logic [2**ADDR_W-1:0] fullExt;
    logic                busyRaw;
    logic                accept;
    logic                inBody;
    logic                parityByte;
    logic                hdrAccept;
    logic                payloadAccept;
    logic                parityAccept;
    logic                doWrite;
    logic [ADDR_W-1:0]   writeDest;
    logic                atLen;
    logic                checkFail;

    assign hdrDest  = data_in[ADDR_LSB +: ADDR_W];
    assign hdrValid = (hdrDest != ADDR_INVALID);

    // Padding the full flags out to the address range lets the invalid code
    // index a constant zero instead of an out-of-range bit.
    assign fullExt = {{(2**ADDR_W-NUM_DEST){1'b0}}, fifo_full};

    // Back-pressure and byte acceptance. In IDLE the target is still on the
    // bus, so busy looks at the incoming header; afterwards it uses the
    // latched destination. CHECK always stalls to give the dead cycle.
    always_comb begin
        busyRaw = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                busyRaw = pkt_valid & hdrValid & fullExt[hdrDest];
                accept  = pkt_valid & ~busyRaw;
            end
            LOAD_DATA: begin
                busyRaw = fullExt[dest_q];
                accept  = ~busyRaw;
            end
            DROP: begin
                accept = 1'b1;
            end
            CHECK: begin
                busyRaw = 1'b1;
            end
            default: ;
        endcase
    end

    assign inBody        = (state_q == LOAD_DATA) | (state_q == DROP);
    assign parityByte    = ~pkt_valid | atLen;
    assign hdrAccept     = accept & (state_q == IDLE);
    assign payloadAccept = accept & inBody & ~parityByte;
    assign parityAccept  = accept & inBody & parityByte;

    router_pkt_chk u_chk (
        .clock       (clock),
        .resetn      (resetn),
        .clear_i     (hdrAccept),
        .update_i    (payloadAccept),
        .data_i      (data_in),
        .atLen_o     (atLen),
        .checkFail_o (checkFail)
    );

    // Write path: header (valid dest) and every LOAD_DATA byte go straight
    // through in the cycle they are accepted. Held low during reset.
    assign writeDest = (state_q == IDLE) ? hdrDest : dest_q;
    assign doWrite   = resetn & accept &
                       (((state_q == IDLE) & hdrValid) | (state_q == LOAD_DATA));

    always_comb begin
        for (int i = 0; i < NUM_DEST; i++) begin
            fifo_we[i] = doWrite & (writeDest == ADDR_W'(i));
        end
    end

    assign fifo_data = data_in;
    assign busy      = resetn & busyRaw;

    // Next-state and status decisions. error/pkt_done are prepared on the
    // parity-byte edge so that they appear, registered, during CHECK.
    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        error_d   = 1'b0;
        pktDone_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdrAccept) begin
                    dest_d  = hdrDest;
                    state_d = hdrValid ? LOAD_DATA : DROP;
                end
            end
            LOAD_DATA: begin
                if (parityAccept) begin
                    state_d   = CHECK;
                    pktDone_d = 1'b1;
                    error_d   = checkFail | pkt_valid;
                end
            end
            DROP: begin
                if (parityAccept) begin
                    state_d   = CHECK;
                    pktDone_d = 1'b1;
                    error_d   = 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            error_q   <= 1'b0;
            pktDone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            error_q   <= error_d;
            pktDone_q <= pktDone_d;
        end
    end

    assign error    = error_q;
    assign pkt_done = pktDone_q;

endmodule

// File: tb/tb_router_src_ctrl.sv
// ---------------------------------------------------------------------------
// tb_router_src_ctrl
// Self-checking bench for router_src_ctrl: directed packet table, hand-built
// stall and reset sequences, and randomized packets against a packet-level
// reference model.
// ---------------------------------------------------------------------------
module tb_router_src_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] dataIn;
    logic       pktValid;
    logic [2:0] fifoFull;
    logic       busy;
    logic       error;
    logic       pktDone;
    logic [7:0] fifoData;
    logic [2:0] fifoWe;

    int checks   = 0;
    int failures = 0;

    // Packet under transmission: bytes and their pkt_valid values.
    logic [7:0] pb [0:65];
    logic       pv [0:65];
    int         nb;

    typedef struct packed {
        logic [7:0]      hdr;
        logic [3:0][7:0] pay;
        logic [7:0]      n;
        logic [7:0]      par;
        logic            parValid;
        logic            expErr;
        logic [7:0]      expWrites;
    } vec_t;

    vec_t vecs [8];

    router_src_ctrl #(.DW(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .data_in   (dataIn),
        .pkt_valid (pktValid),
        .fifo_full (fifoFull),
        .busy      (busy),
        .error     (error),
        .pkt_done  (pktDone),
        .fifo_data (fifoData),
        .fifo_we   (fifoWe)
    );

    always #5 clock = ~clock;

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input string name,
                               input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s actual=%0h required=%0h at %0t", tag, name, act, exp, $time);
        end
    endtask

    // Drives the packet held in pb/pv, starting just after a rising edge.
    // Expectations come from the packet description: the target is the
    // header destination, it is stalled whenever its FIFO is full, and every
    // byte of a valid-destination packet is written as it is accepted.
    task automatic applyStimulus(input string tag, input logic expErr, input int expWrites,
                                 input bit randFull, input logic [2:0] fullBase,
                                 input int stallByte, input int stallLen,
                                 output int busySeen);
        logic [1:0] dest;
        logic       tgtFull;
        logic [2:0] expWe;
        int         writes;
        int         waitCnt;
        int         stallLeft;
        bit         accepted;
        dest     = pb[0][1:0];
        writes   = 0;
        busySeen = 0;
        for (int k = 0; k < nb; k++) begin
            dataIn    = pb[k];
            pktValid  = pv[k];
            stallLeft = (k == stallByte) ? stallLen : 0;
            waitCnt   = 0;
            accepted  = 0;
            while (!accepted && waitCnt < 200) begin
                if (randFull) fifoFull = 3'($urandom_range(0, 7));
                else          fifoFull = fullBase;
                if (stallLeft > 0 && dest != 2'd3) fifoFull = fifoFull | (3'b001 << dest);
                tgtFull = (dest != 2'd3) && (((fifoFull >> dest) & 3'b001) != 3'b000);
                expWe   = (!tgtFull && dest != 2'd3) ? (3'b001 << dest) : 3'b000;
                @(negedge clock);
                checkOutput(tag, "busy", 8'(busy), 8'(tgtFull));
                checkOutput(tag, "fifo_we", 8'(fifoWe), 8'(expWe));
                if (!tgtFull) checkOutput(tag, "fifo_data", fifoData, pb[k]);
                checkOutput(tag, "pkt_done_early", 8'(pktDone), 8'd0);
                checkOutput(tag, "error_early", 8'(error), 8'd0);
                if (fifoWe != 3'b000) writes++;
                if (tgtFull) busySeen++;
                @(posedge clock);
                #1;
                if (!tgtFull) accepted = 1;
                else begin
                    waitCnt++;
                    if (stallLeft > 0) stallLeft--;
                end
            end
            if (!accepted) checkOutput(tag, "byte_timeout", 8'd1, 8'd0);
        end
        pktValid = 1'b0;
        dataIn   = 8'($urandom);
        @(negedge clock);
        checkOutput(tag, "check_busy", 8'(busy), 8'd1);
        checkOutput(tag, "pkt_done", 8'(pktDone), 8'd1);
        checkOutput(tag, "error", 8'(error), 8'(expErr));
        checkOutput(tag, "check_we", 8'(fifoWe), 8'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput(tag, "done_clear", 8'(pktDone), 8'd0);
        checkOutput(tag, "error_clear", 8'(error), 8'd0);
        checkOutput(tag, "idle_busy", 8'(busy), 8'd0);
        @(posedge clock);
        #1;
        checkOutput(tag, "write_count", 8'(writes), 8'(expWrites));
    endtask

    // Loads one table vector into the packet buffer.
    task automatic loadVec(input vec_t v);
        nb    = 0;
        pb[0] = v.hdr;
        pv[0] = 1'b1;
        for (int k = 0; k < int'(v.n); k++) begin
            pb[k+1] = v.pay[k];
            pv[k+1] = 1'b1;
        end
        pb[int'(v.n)+1] = v.par;
        pv[int'(v.n)+1] = v.parValid;
        nb = int'(v.n) + 2;
    endtask

    initial begin
        int         busySeen;
        logic [1:0] rDest;
        int         rLen;
        int         rN;
        int         mode;
        logic       rParValid;
        logic [7:0] x;
        logic [7:0] b;
        logic [7:0] par;
        logic       expErr;

        vecs[0] = '{8'h0D, {8'h00, 8'h33, 8'h22, 8'h11}, 8'd3, 8'h0D, 1'b0, 1'b0, 8'd5};
        vecs[1] = '{8'h0D, {8'h00, 8'h33, 8'h22, 8'h11}, 8'd3, 8'h0C, 1'b0, 1'b1, 8'd5};
        vecs[2] = '{8'h07, {8'h00, 8'h00, 8'h00, 8'hAA}, 8'd1, 8'hAD, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{8'h0D, {8'h00, 8'h00, 8'h00, 8'h11}, 8'd1, 8'h22, 1'b0, 1'b1, 8'd3};
        vecs[4] = '{8'h04, {8'h00, 8'h00, 8'h00, 8'h55}, 8'd1, 8'h51, 1'b0, 1'b0, 8'd3};
        vecs[5] = '{8'h02, {8'h00, 8'h00, 8'h00, 8'h00}, 8'd0, 8'h02, 1'b0, 1'b0, 8'd2};
        vecs[6] = '{8'h00, {8'h00, 8'h00, 8'h00, 8'h00}, 8'd0, 8'h00, 1'b1, 1'b1, 8'd2};
        vecs[7] = '{8'h05, {8'h00, 8'h00, 8'h00, 8'h10}, 8'd1, 8'h15, 1'b1, 1'b1, 8'd3};

        // Reset state: outputs quiet and busy/we forced low even with a
        // header on the bus and every FIFO full.
        resetn   = 1'b0;
        dataIn   = 8'h0D;
        pktValid = 1'b1;
        fifoFull = 3'b000;
        #2;
        checkOutput("reset", "busy", 8'(busy), 8'd0);
        checkOutput("reset", "fifo_we", 8'(fifoWe), 8'd0);
        checkOutput("reset", "error", 8'(error), 8'd0);
        checkOutput("reset", "pkt_done", 8'(pktDone), 8'd0);
        fifoFull = 3'b111;
        #1;
        checkOutput("reset", "busy_full", 8'(busy), 8'd0);
        @(negedge clock);
        resetn   = 1'b1;
        pktValid = 1'b0;
        fifoFull = 3'b000;
        @(posedge clock);
        #1;

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            loadVec(vecs[i]);
            applyStimulus($sformatf("vec%0d", i), vecs[i].expErr, int'(vecs[i].expWrites),
                          1'b0, 3'b000, -1, 0, busySeen);
        end

        // Target FIFO full for three cycles while 0x33 waits; FIFO 0 full
        // all along must not matter.
        $display("[TB] stall sequence");
        loadVec(vecs[0]);
        applyStimulus("stall", 1'b0, 5, 1'b0, 3'b001, 3, 3, busySeen);
        checkOutput("stall", "busy_cycles", 8'(busySeen), 8'd3);

        // Reset in the middle of a packet, then a clean packet.
        $display("[TB] reset mid-packet");
        dataIn   = 8'h0D;
        pktValid = 1'b1;
        fifoFull = 3'b000;
        @(negedge clock);
        checkOutput("rstmid", "hdr_we", 8'(fifoWe), 8'd2);
        @(posedge clock);
        #1;
        dataIn = 8'h11;
        @(negedge clock);
        checkOutput("rstmid", "pay_we", 8'(fifoWe), 8'd2);
        @(posedge clock);
        #1;
        dataIn   = 8'h22;
        fifoFull = 3'b010;
        @(negedge clock);
        checkOutput("rstmid", "stalled", 8'(busy), 8'd1);
        resetn = 1'b0;
        #1;
        checkOutput("rstmid", "busy", 8'(busy), 8'd0);
        checkOutput("rstmid", "fifo_we", 8'(fifoWe), 8'd0);
        fifoFull = 3'b000;
        #1;
        checkOutput("rstmid", "we_unstalled", 8'(fifoWe), 8'd0);
        @(posedge clock);
        #1;
        checkOutput("rstmid", "error", 8'(error), 8'd0);
        @(negedge clock);
        resetn   = 1'b1;
        pktValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            checkOutput("rstmid", "no_done", 8'(pktDone), 8'd0);
            checkOutput("rstmid", "no_error", 8'(error), 8'd0);
        end
        @(posedge clock);
        #1;
        loadVec(vecs[4]);
        applyStimulus("after_rst", 1'b0, 3, 1'b0, 3'b000, -1, 0, busySeen);

        // Random packets with random FIFO pressure. The reference model works
        // from the packet description alone: error if dropped, short, parity
        // byte flagged valid, or the XOR of header+payload differs.
        $display("[TB] random packets");
        for (int r = 0; r < 40; r++) begin
            rDest     = 2'($urandom_range(0, 3));
            rLen      = (r % 10 == 9) ? 63 : int'($urandom_range(0, 6));
            mode      = int'($urandom_range(0, 3));
            rN        = rLen;
            rParValid = 1'b0;
            if (mode == 2 && rLen > 0) rN = int'($urandom_range(0, rLen - 1));
            if (mode == 3) rParValid = 1'b1;
            pb[0] = {6'(rLen), rDest};
            pv[0] = 1'b1;
            x     = pb[0];
            for (int k = 0; k < rN; k++) begin
                b       = 8'($urandom);
                pb[k+1] = b;
                pv[k+1] = 1'b1;
                x       = x ^ b;
            end
            par = x;
            if (mode == 1) par = x ^ (8'h01 << $urandom_range(0, 7));
            pb[rN+1] = par;
            pv[rN+1] = rParValid;
            nb       = rN + 2;
            expErr   = (rDest == 2'd3) || (rN != rLen) || rParValid || (par != x);
            applyStimulus($sformatf("rand%0d", r), expErr, (rDest == 2'd3) ? 0 : rN + 2,
                          1'b1, 3'b000, -1, 0, busySeen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
